// File: rtl/block_sync_ctrl.sv
// 64b/66b RX block-lock controller: sync-header test windows, gearbox slip, lock report.
// Optional slip statistics counter enabled with `define BLOCK_SYNC_STATS_EN.
module block_sync_ctrl #(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_HOLDOFF = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_init_done,
  input  logic        i_valid,
  input  logic [1:0]  i_header,
  output logic        o_slip,
  output logic        o_block_lock,
  output logic [15:0] o_slip_count
);

  localparam int CW = $clog2(SH_CNT_MAX) + 1;
  localparam int IW = $clog2(SH_INVLD_MAX) + 1;
  localparam int HW = $clog2(SLIP_HOLDOFF) + 1;

  typedef enum logic [2:0] {
    S_LOCK_INIT,
    S_RESET_CNT,
    S_TEST_SH,
    S_SLIP,
    S_HOLDOFF
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_sh_cnt;
  logic [CW-1:0] w_sh_cnt;
  logic [IW-1:0] r_inv_cnt;
  logic [IW-1:0] w_inv_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_cnt;
  logic          r_lock;
  logic          w_lock;

  logic          w_hdr_ok;
  logic [CW-1:0] w_sh_inc;
  logic [IW-1:0] w_inv_inc;
  logic [HW-1:0] w_hold_inc;

  // A legal sync header has exactly one bit set.
  assign w_hdr_ok   = i_header[1] ^ i_header[0];
  assign w_sh_inc   = r_sh_cnt + CW'(1);
  assign w_inv_inc  = r_inv_cnt + IW'(1);
  assign w_hold_inc = r_hold_cnt + HW'(1);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_LOCK_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and next-counter decode; init low overrides any sample.
  always_comb begin
    w_next     = r_state;
    w_sh_cnt   = r_sh_cnt;
    w_inv_cnt  = r_inv_cnt;
    w_hold_cnt = r_hold_cnt;
    w_lock     = r_lock;
    if (!i_init_done) begin
      w_next     = S_LOCK_INIT;
      w_sh_cnt   = '0;
      w_inv_cnt  = '0;
      w_hold_cnt = '0;
      w_lock     = 1'b0;
    end else begin
      unique case (r_state)
        S_LOCK_INIT: begin
          w_next     = S_RESET_CNT;
          w_sh_cnt   = '0;
          w_inv_cnt  = '0;
          w_hold_cnt = '0;
          w_lock     = 1'b0;
        end
        S_RESET_CNT: begin
          w_next     = S_TEST_SH;
          w_sh_cnt   = '0;
          w_inv_cnt  = '0;
          w_hold_cnt = '0;
        end
        S_TEST_SH: begin
          if (i_valid) begin
            w_sh_cnt = w_sh_inc;
            if (w_hdr_ok) begin
              if (w_sh_inc == CW'(SH_CNT_MAX)) begin
                if (r_inv_cnt == '0) begin
                  w_lock = 1'b1;
                end
                w_sh_cnt  = '0;
                w_inv_cnt = '0;
              end
            end else begin
              w_inv_cnt = w_inv_inc;
              if (!r_lock ||
                  (w_inv_inc == IW'(SH_INVLD_MAX))) begin
                w_next     = S_SLIP;
                w_sh_cnt   = '0;
                w_inv_cnt  = '0;
                w_hold_cnt = '0;
                w_lock     = 1'b0;
              end else if (w_sh_inc == CW'(SH_CNT_MAX)) begin
                w_sh_cnt  = '0;
                w_inv_cnt = '0;
              end
            end
          end
        end
        S_SLIP, S_HOLDOFF: begin
          // Samples after a slip are flushed; the SLIP cycle's sample counts.
          w_sh_cnt  = '0;
          w_inv_cnt = '0;
          if (i_valid) begin
            if (w_hold_inc >= HW'(SLIP_HOLDOFF)) begin
              w_next     = S_TEST_SH;
              w_hold_cnt = '0;
            end else begin
              w_next     = S_HOLDOFF;
              w_hold_cnt = w_hold_inc;
            end
          end else begin
            w_next = S_HOLDOFF;
          end
        end
        default: begin
          w_next     = S_LOCK_INIT;
          w_sh_cnt   = '0;
          w_inv_cnt  = '0;
          w_hold_cnt = '0;
          w_lock     = 1'b0;
        end
      endcase
    end
  end

  // Window counters, holdoff counter and lock flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sh_cnt   <= '0;
      r_inv_cnt  <= '0;
      r_hold_cnt <= '0;
      r_lock     <= 1'b0;
    end else begin
      r_sh_cnt   <= w_sh_cnt;
      r_inv_cnt  <= w_inv_cnt;
      r_hold_cnt <= w_hold_cnt;
      r_lock     <= w_lock;
    end
  end

  // Moore outputs: slip pulse is the single SLIP cycle.
  always_comb begin
    o_slip       = (r_state == S_SLIP);
    o_block_lock = r_lock;
  end

`ifdef BLOCK_SYNC_STATS_EN
  logic [15:0] r_slip_count;

  // Saturating slip counter, cleared only by the async reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_slip_count <= '0;
    end else if ((w_next == S_SLIP) &&
                 (r_state != S_SLIP) &&
                 (r_slip_count != 16'hFFFF)) begin
      r_slip_count <= r_slip_count + 16'd1;
    end
  end

  assign o_slip_count = r_slip_count;
`else
  assign o_slip_count = 16'h0000;
`endif

endmodule

// File: tb/tb_block_sync_ctrl.sv
// Directed bench for block_sync_ctrl with a sample-level lock model.
// Model tracks windows/holdoff as plain counts of accepted headers.
module tb_block_sync_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  header = 2'b00;
  logic        o_slip;
  logic        o_block_lock;
  logic [15:0] o_slip_count;

  int n_checks = 0;
  int n_errors = 0;

  block_sync_ctrl dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_init_done  (init_done),
    .i_valid      (valid),
    .i_header     (header),
    .o_slip       (o_slip),
    .o_block_lock (o_block_lock),
    .o_slip_count (o_slip_count)
  );

  always #5 clk = ~clk;

  // Model state: samples still dropped at startup, holdoff samples left,
  // headers seen in window, bad headers in window.
  int          m_start = 2;
  int          m_hold = 0;
  int          m_win = 0;
  int          m_bad = 0;
  logic        m_lock = 1'b0;
  logic        m_slip = 1'b0;
  logic [15:0] m_cnt = 16'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_start = 2; m_hold = 0; m_win = 0; m_bad = 0;
      m_lock = 0; m_slip = 0; m_cnt = 0;
    end else if (!init_done) begin
      m_start = 2; m_hold = 0; m_win = 0; m_bad = 0;
      m_lock = 0; m_slip = 0;
    end else begin
      m_slip = 0;
      if (m_start > 0) begin
        m_start--;
      end else if (valid) begin
        if (m_hold > 0) begin
          m_hold--;
        end else begin
          bit bad;
          bad = (header == 2'b00) || (header == 2'b11);
          m_win++;
          if (bad) m_bad++;
          if (bad && (!m_lock || m_bad == 16)) begin
            m_slip = 1; m_lock = 0;
            m_win = 0; m_bad = 0; m_hold = 4;
`ifdef BLOCK_SYNC_STATS_EN
            if (m_cnt != 16'hFFFF) m_cnt++;
`endif
          end else if (m_win == 64) begin
            if (m_bad == 0) m_lock = 1;
            m_win = 0; m_bad = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_slip", {15'd0, o_slip}, {15'd0, m_slip});
      chk("model_lock", {15'd0, o_block_lock}, {15'd0, m_lock});
      chk("model_count", o_slip_count, m_cnt);
    end
  end

  task automatic step(input logic v, input logic [1:0] h);
    valid = v;
    header = h;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic s, input logic l);
    chk({name, "_slip"}, {15'd0, o_slip}, {15'd0, s});
    chk({name, "_lock"}, {15'd0, o_block_lock}, {15'd0, l});
  endtask

  initial begin
    int n;
    int c;
    #3;
    chk_out("reset", 1'b0, 1'b0);
    chk("reset_count", o_slip_count, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_done = 1'b1;
    repeat (3) step(1'b0, 2'b00);

    // 1: lock after 64 good headers
    for (int i = 0; i < 63; i++) step(1'b1, 2'b01);
    chk_out("t1_63", 1'b0, 1'b0);
    step(1'b1, 2'b10);
    chk_out("t1_64", 1'b0, 1'b1);

    // 3: 15 bad in a window keeps lock, 16 bad slips
    for (int i = 0; i < 64; i++)
      step(1'b1, (i % 4 == 0 && i < 60) ? 2'b00 : 2'b01);
    chk_out("t3_15bad", 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, 2'b11);
    chk_out("t3_15run", 1'b0, 1'b1);
    step(1'b1, 2'b11);
    chk_out("t3_16bad", 1'b1, 1'b0);

    // 2: holdoff then unlocked single bad header slips
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01);
    step(1'b1, 2'b00);
    chk_out("t2_slip1", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b11);
      chk_out("t2_hold", 1'b0, 1'b0);
    end
    step(1'b1, 2'b11);
    chk_out("t2_slip2", 1'b1, 1'b0);

    // 4: gaps with bad header on invalid cycles
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01);
    n = 0;
    c = 0;
    while (n < 64) begin
      if (c % 33 == 32) begin
        step(1'b0, 2'b00);
      end else begin
        step(1'b1, 2'b01);
        n++;
        if (n == 63) chk_out("t4_63", 1'b0, 1'b0);
      end
      c++;
    end
    chk_out("t4_64", 1'b0, 1'b1);

    // 5: async reset during the slip pulse
    for (int i = 0; i < 16; i++) step(1'b1, 2'b11);
    chk_out("t5_slip", 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t5_rst", 1'b0, 1'b0);
    chk("t5_rst_count", o_slip_count, 16'h0);
    valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) step(1'b0, 2'b00);
    for (int i = 0; i < 63; i++) step(1'b1, 2'b01);
    chk_out("t5_63", 1'b0, 1'b0);
    step(1'b1, 2'b01);
    chk_out("t5_64", 1'b0, 1'b1);

    // init drop coincident with a bad sample
    init_done = 1'b0;
    step(1'b1, 2'b00);
    chk_out("init_drop", 1'b0, 1'b0);
    init_done = 1'b1;
    repeat (2) step(1'b0, 2'b00);

    // 6: three slips for the statistics counter
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2'b00);
      chk_out("t6_slip", 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 2'b01);
    end
    step(1'b0, 2'b00);
`ifdef BLOCK_SYNC_STATS_EN
    chk("t6_count", o_slip_count, 16'd3);
`else
    chk("t6_count", o_slip_count, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
